// File: rtl/train_timing_controller.sv
// Level-crossing gate controller: measures a train's s1->s2 transit time, hands it to an
// external predictor, then counts the predicted closing time down in 1 ms ticks.
module train_timing_controller #(
  parameter int TICK_DIV     = 50000,
  parameter int PRED_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s1,
  input  logic        s2,
  input  logic        s3,
  input  logic        clr,
  output logic        pred_start,
  output logic [18:0] meas_time,
  input  logic        pred_done,
  input  logic [18:0] pred_time,
  output logic [18:0] remaining,
  output logic        gate_warn,
  output logic        gate_close,
  output logic        err,
  output logic [2:0]  state
);

  // state     | meaning
  // IDLE      | waiting for a train at s1
  // MEASURE   | counting ms between s1 and s2
  // PREDICT   | waiting on the predictor datapath
  // COUNTDOWN | gate warning, counting predicted ms down to zero
  // CLOSED    | gate down until the train clears s3
  // ERROR     | gate down, latched until clr
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MEASURE   = 3'd1;
  localparam logic [2:0] ST_PREDICT   = 3'd2;
  localparam logic [2:0] ST_COUNTDOWN = 3'd3;
  localparam logic [2:0] ST_CLOSED    = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd5;

  localparam int          PW     = $clog2(TICK_DIV);
  localparam int          TW     = $clog2(PRED_TIMEOUT + 1);
  localparam logic [18:0] MS_MAX = 19'h7FFFF;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic          s1_q, s2_q, s3_q;
  logic          s1_rise, s2_rise, s3_rise;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [18:0]   ms_cnt;
  logic [TW-1:0] tmr;
  logic [18:0]   rem_q;
  logic          entering;

  assign s1_rise  = s1 & ~s1_q;
  assign s2_rise  = s2 & ~s2_q;
  assign s3_rise  = s3 & ~s3_q;
  assign tick     = (pre_cnt == PW'(TICK_DIV - 1));
  assign entering = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s1_rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        // s2 takes priority over a coincident tick so meas_time is the pre-increment count
        if (s2_rise) state_d = (ms_cnt == '0) ? ST_ERROR : ST_PREDICT;
        else if (tick && ms_cnt == MS_MAX - 19'd1) state_d = ST_ERROR;
      end
      ST_PREDICT: begin
        if (pred_done) state_d = (pred_time == '0) ? ST_CLOSED : ST_COUNTDOWN;
        else if (tmr == '0) state_d = ST_ERROR;
      end
      ST_COUNTDOWN: begin
        if (tick && rem_q <= 19'd1) state_d = ST_CLOSED;
      end
      ST_CLOSED: begin
        if (s3_rise) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (clr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      s3_q       <= 1'b1;
      pre_cnt    <= '0;
      ms_cnt     <= '0;
      tmr        <= '0;
      meas_time  <= '0;
      rem_q      <= '0;
      pred_start <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1;
      s2_q    <= s2;
      s3_q    <= s3;

      if (entering && (state_d == ST_MEASURE || state_d == ST_COUNTDOWN)) pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else pre_cnt <= pre_cnt + PW'(1);

      pred_start <= entering && (state_d == ST_PREDICT);

      if (state_q == ST_IDLE && s1_rise) ms_cnt <= '0;
      else if (state_q == ST_MEASURE && tick && !s2_rise) ms_cnt <= ms_cnt + 19'd1;

      if (state_q == ST_MEASURE && state_d == ST_PREDICT) meas_time <= ms_cnt;

      // timeout is a down-counter: PREDICT cycle k holds PRED_TIMEOUT-1-k
      if (entering && state_d == ST_PREDICT) tmr <= TW'(PRED_TIMEOUT - 1);
      else if (state_q == ST_PREDICT && tmr != '0) tmr <= tmr - TW'(1);

      if (state_q == ST_PREDICT && state_d == ST_COUNTDOWN) rem_q <= pred_time;
      else if (state_q == ST_COUNTDOWN && tick) rem_q <= rem_q - 19'd1;
      else if (state_q != ST_COUNTDOWN) rem_q <= '0;
    end
  end

  assign state      = state_q;
  assign remaining  = rem_q;
  assign gate_warn  = (state_q == ST_COUNTDOWN);
  assign gate_close = (state_q == ST_CLOSED) || (state_q == ST_ERROR);
  assign err        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_train_timing_controller.sv
// Directed bench for train_timing_controller with TICK_DIV=4, PRED_TIMEOUT=16.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_train_timing_controller;

  logic        clk = 1'b0;
  logic        rst, s1, s2, s3, clr, pred_done;
  logic [18:0] pred_time;
  logic        pred_start, gate_warn, gate_close, err;
  logic [18:0] meas_time, remaining;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  train_timing_controller #(.TICK_DIV(4), .PRED_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .s1(s1), .s2(s2), .s3(s3), .clr(clr),
    .pred_start(pred_start), .meas_time(meas_time), .pred_done(pred_done),
    .pred_time(pred_time), .remaining(remaining), .gate_warn(gate_warn),
    .gate_close(gate_close), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sensors_low();
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; clr = 1'b0; pred_done = 1'b0; pred_time = '0;
    cyc(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sensors_low();
    cyc(1);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (meas_time !== 19'd0 || remaining !== 19'd0) begin n_bad++; $display("FAIL reset_regs: meas=%0d rem=%0d want 0 0", meas_time, remaining); end
    n_cmp++; if ({pred_start, gate_warn, gate_close, err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {pred_start, gate_warn, gate_close, err}); end
    rst = 1'b0;
    pred_done = 1'b1; pred_time = 19'd5;
    cyc(1);
    pred_done = 1'b0;
    n_cmp++; if (state !== 3'd0 || remaining !== 19'd0) begin n_bad++; $display("FAIL reset_pred_done: state=%0d rem=%0d want 0 0", state, remaining); end
  endtask

  task automatic test_nominal();
    int starts;
    int warns;
    s1 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL nom_measure: state=%0d want 1", state); end
    cyc(40);
    s2 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL nom_predict: state=%0d want 2", state); end
    n_cmp++; if (meas_time !== 19'd10) begin n_bad++; $display("FAIL nom_meas_time: got %0d want 10", meas_time); end
    starts = pred_start ? 1 : 0;
    repeat (5) begin
      cyc(1);
      if (pred_start) starts++;
    end
    pred_done = 1'b1; pred_time = 19'd3;
    cyc(1);
    pred_done = 1'b0; pred_time = '0;
    n_cmp++; if (starts !== 1) begin n_bad++; $display("FAIL nom_pred_start_pulses: got %0d want 1", starts); end
    n_cmp++; if (meas_time !== 19'd10) begin n_bad++; $display("FAIL nom_meas_hold: got %0d want 10", meas_time); end
    warns = 0;
    for (int i = 0; i < 12; i++) begin
      if (gate_warn) warns++;
      n_cmp++; if (remaining !== 19'(3 - i / 4)) begin n_bad++; $display("FAIL nom_remaining[%0d]: got %0d want %0d", i, remaining, 3 - i / 4); end
      cyc(1);
    end
    n_cmp++; if (warns !== 12) begin n_bad++; $display("FAIL nom_warn_cycles: got %0d want 12", warns); end
    n_cmp++; if (state !== 3'd4 || gate_close !== 1'b1 || gate_warn !== 1'b0 || remaining !== 19'd0) begin
      n_bad++; $display("FAIL nom_closed: state=%0d close=%b warn=%b rem=%0d want 4 1 0 0", state, gate_close, gate_warn, remaining);
    end
    s3 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd0 || gate_close !== 1'b0) begin n_bad++; $display("FAIL nom_exit: state=%0d close=%b want 0 0", state, gate_close); end
    sensors_low();
  endtask

  task automatic test_fast_train();
    s1 = 1'b1;
    cyc(2);
    s2 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd5 || err !== 1'b1 || gate_close !== 1'b1) begin
      n_bad++; $display("FAIL fast_error: state=%0d err=%b close=%b want 5 1 1", state, err, gate_close);
    end
    s3 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL fast_s3_ignored: state=%0d want 5", state); end
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    n_cmp++; if (state !== 3'd0 || err !== 1'b0) begin n_bad++; $display("FAIL fast_clr: state=%0d err=%b want 0 0", state, err); end
    sensors_low();
  endtask

  task automatic test_timeout();
    s1 = 1'b1;
    cyc(1);
    cyc(8);
    s2 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd2 || meas_time !== 19'd2 || pred_start !== 1'b1) begin
      n_bad++; $display("FAIL tmo_enter: state=%0d meas=%0d start=%b want 2 2 1", state, meas_time, pred_start);
    end
    cyc(15);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL tmo_last_wait: state=%0d want 2", state); end
    cyc(1);
    n_cmp++; if (state !== 3'd5 || err !== 1'b1) begin n_bad++; $display("FAIL tmo_error: state=%0d err=%b want 5 1", state, err); end
    pred_done = 1'b1; pred_time = 19'd7;
    cyc(1);
    pred_done = 1'b0;
    n_cmp++; if (state !== 3'd5 || remaining !== 19'd0) begin n_bad++; $display("FAIL tmo_late_done: state=%0d rem=%0d want 5 0", state, remaining); end
    clr = 1'b1;
    cyc(1);
    sensors_low();
  endtask

  task automatic test_zero_pred();
    logic warn_seen;
    warn_seen = 1'b0;
    s1 = 1'b1;
    cyc(1);
    cyc(5);
    s2 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd2 || meas_time !== 19'd1) begin n_bad++; $display("FAIL zero_predict: state=%0d meas=%0d want 2 1", state, meas_time); end
    cyc(1);
    warn_seen |= gate_warn;
    pred_done = 1'b1; pred_time = 19'd0;
    cyc(1);
    pred_done = 1'b0;
    warn_seen |= gate_warn;
    n_cmp++; if (state !== 3'd4 || warn_seen !== 1'b0 || remaining !== 19'd0) begin
      n_bad++; $display("FAIL zero_closed: state=%0d warn_seen=%b rem=%0d want 4 0 0", state, warn_seen, remaining);
    end
    s3 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL zero_exit: state=%0d want 0", state); end
    sensors_low();
  endtask

  task automatic test_edge_cases();
    s2 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL edge_s2_in_idle: state=%0d want 0", state); end
    sensors_low();
    s1 = 1'b1; s2 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL edge_s1_s2_together: state=%0d want 1", state); end
    cyc(1);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL edge_s2_discarded: state=%0d want 1", state); end
    s1 = 1'b0;
    cyc(1);
    s1 = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL edge_s1_in_measure: state=%0d want 1", state); end
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL edge_s1_held_reset: state=%0d want 0", state); end
    sensors_low();
  endtask

  task automatic test_reset_countdown();
    s1 = 1'b1;
    cyc(1);
    cyc(5);
    s2 = 1'b1;
    cyc(1);
    cyc(1);
    pred_done = 1'b1; pred_time = 19'd3;
    cyc(1);
    pred_done = 1'b0;
    cyc(4);
    n_cmp++; if (state !== 3'd3 || remaining !== 19'd2) begin n_bad++; $display("FAIL rstcd_setup: state=%0d rem=%0d want 3 2", state, remaining); end
    rst = 1'b1;
    cyc(1);
    n_cmp++; if (state !== 3'd0 || remaining !== 19'd0 || meas_time !== 19'd0) begin
      n_bad++; $display("FAIL rstcd_regs: state=%0d rem=%0d meas=%0d want 0 0 0", state, remaining, meas_time);
    end
    n_cmp++; if ({pred_start, gate_warn, gate_close, err} !== 4'b0000) begin
      n_bad++; $display("FAIL rstcd_flags: got %b want 0000", {pred_start, gate_warn, gate_close, err});
    end
    rst = 1'b0;
    sensors_low();
  endtask

  initial begin
    rst = 1'b1; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; clr = 1'b0;
    pred_done = 1'b0; pred_time = '0;
    test_reset();
    test_nominal();
    test_fast_train();
    test_timeout();
    test_zero_pred();
    test_edge_cases();
    test_reset_countdown();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/train_timing_controller.md
TRAIN_TIMING_CONTROLLER -- requirements
Module: train_timing_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000: clk cycles per 1 ms tick; must be >= 2.
REQ-002 Parameter PRED_TIMEOUT, default 1024: max clk cycles to wait for pred_done.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s1  input  1  approach sensor 1, synchronous level.
REQ-006 s2  input  1  approach sensor 2, synchronous level.
REQ-007 s3  input  1  exit sensor, synchronous level.
REQ-008 clr  input  1  clears ERROR state.
REQ-009 pred_start  output  1  one-cycle request to the predictor datapath.
REQ-010 meas_time  output  19  measured s1->s2 time in ms, sent to the predictor.
REQ-011 pred_done  input  1  predictor result valid, one cycle.
REQ-012 pred_time  input  19  predicted ms until gate must close; sampled when pred_done=1.
REQ-013 remaining  output  19  ms left in countdown.
REQ-014 gate_warn  output  1  high in COUNTDOWN.
REQ-015 gate_close  output  1  high in CLOSED and ERROR.
REQ-016 err  output  1  high in ERROR.
REQ-017 state  output  3  IDLE=0, MEASURE=1, PREDICT=2, COUNTDOWN=3, CLOSED=4, ERROR=5.

Function
REQ-018 Edge detect: sX_rise = sX & ~sX_q, where sX_q is sX registered each cycle.
REQ-019 Prescaler runs 0..TICK_DIV-1; tick=1 in the cycle its value is TICK_DIV-1, then it wraps to 0.
REQ-020 Prescaler clears on entry to MEASURE or COUNTDOWN, so the first tick comes TICK_DIV cycles after entry.
REQ-021 IDLE: s1_rise -> MEASURE next cycle; ms counter clears to 0.
REQ-022 MEASURE: ms counter +1 per tick.
REQ-023 MEASURE: s2_rise with count>0 -> PREDICT; meas_time loads the count.
REQ-024 MEASURE: s2_rise with count=0 -> ERROR (zero-divide guard).
REQ-025 MEASURE: count reaching 19'h7FFFF -> ERROR (overspeed/stall guard).
REQ-026 s2_rise and tick in the same cycle: s2 wins; meas_time takes the pre-increment count.
REQ-027 PREDICT: pred_start=1 in exactly the first cycle in PREDICT; meas_time stable while in PREDICT.
REQ-028 PREDICT: pred_done with pred_time>0 -> COUNTDOWN; remaining loads pred_time.
REQ-029 PREDICT: pred_done with pred_time=0 -> CLOSED directly.
REQ-030 PREDICT: no pred_done within PRED_TIMEOUT cycles of pred_start -> ERROR.
REQ-031 COUNTDOWN: remaining -1 per tick; the tick that makes it 0 -> CLOSED next cycle.
REQ-032 CLOSED: s3_rise -> IDLE.
REQ-033 ERROR: clr=1 -> IDLE; s1/s2/s3 ignored.
REQ-034 s1_rise outside IDLE, s2_rise outside MEASURE, s3_rise outside CLOSED: all ignored, no state change.
REQ-035 pred_done outside PREDICT: ignored.
REQ-036 s1_rise and s2_rise in the same IDLE cycle: s1 accepted, s2 edge discarded.
REQ-037 meas_time holds its value until the next load.
REQ-038 remaining reads 0 outside COUNTDOWN, except in the cycle it loads.

Reset
REQ-039 rst=1 at any clk edge, including mid-operation: state=IDLE, prescaler=0, ms counter=0, meas_time=0, remaining=0.
REQ-040 rst=1 at any clk edge: pred_start=0, gate_warn=0, gate_close=0, err=0.
REQ-041 Reset sets s1_q, s2_q, s3_q to 1, so a sensor held high through reset release gives no edge.
REQ-042 A pred_done arriving in the cycle after reset is ignored.

Verification (TICK_DIV=4, PRED_TIMEOUT=16)
REQ-043 Nominal run:
- s1 rises; 40 cycles later s2 rises.
- Required: meas_time=10; one pred_start pulse.
- Model returns pred_done with pred_time=3 five cycles later: gate_warn for 12 cycles, remaining 3->2->1->0.
- gate_close=1; s3 rises -> state=0.
REQ-044 Fast train: s2 rises 2 cycles after s1 enters MEASURE -> state=5, err=1, gate_close=1; clr -> state=0.
REQ-045 Predictor timeout: no pred_done for 16 cycles after pred_start -> state=5; a late pred_done leaves state=5.
REQ-046 Zero prediction: pred_time=0 -> state=4 the cycle after pred_done; gate_warn never asserted.
REQ-047 Edge cases, each with its required response:
- s1 and s2 rise together in IDLE: state=1.
- s1 rises again in MEASURE: no change.
- s1 held high across reset release: state stays 0.
REQ-048 Reset mid-COUNTDOWN (remaining=2): next cycle all outputs 0, state=0.
